// File: rtl/lo_passthru_seq_if.sv
// Bundle between the LF read sequencer and its ARM-facing logic: cycle
// control and phase lengths in, drive enable and edge-period results out.
interface lo_passthru_seq_if #(
    parameter int CNT_W = 24,
    parameter int PER_W = 12,
    parameter int EC_W  = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] charge_len;
    logic [7:0]       guard_len;
    logic [CNT_W-1:0] listen_len;
    logic             cross_lo;
    logic             mod_en;
    logic             busy;
    logic             done;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic [EC_W-1:0]  edge_cnt;

    modport master (
        output start, abort, charge_len, guard_len, listen_len, cross_lo,
        input  mod_en, busy, done, period, period_valid, edge_cnt
    );

    modport slave (
        input  start, abort, charge_len, guard_len, listen_len, cross_lo,
        output mod_en, busy, done, period, period_valid, edge_cnt
    );
endinterface

// File: rtl/lo_passthru_seq.sv
// LF charge-then-listen read sequencer: drives mod_en for the charge phase,
// waits a guard gap, then measures cross_lo rising-edge periods in a listen window.
module lo_passthru_seq #(
    parameter int CNT_W = 24,
    parameter int PER_W = 12,
    parameter int EC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lo_passthru_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHARGE, GUARD, LISTEN, DONE} state_t;

    state_t           state_q;
    state_t           nxt_st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] nxt_cnt_d;
    logic [7:0]       glen_q;
    logic [CNT_W-1:0] llen_q;
    logic [CNT_W-1:0] c_sel_d;
    logic [7:0]       g_sel_d;
    logic [CNT_W-1:0] l_sel_d;
    logic             advance_d;
    logic             edge_hit_d;

    logic             sync_p0_q;
    logic             sync_p1_q;
    logic             sync_p2_q;
    logic             rise_p3_q;

    logic             armed_q;
    logic [PER_W-1:0] per_cnt_q;
    logic             mod_en_q;
    logic             busy_q;
    logic             done_q;
    logic             pv_q;
    logic [PER_W-1:0] period_q;
    logic [EC_W-1:0]  edge_cnt_q;

    function automatic logic [PER_W-1:0] sat_inc_per(input logic [PER_W-1:0] v);
        return (&v) ? v : v + PER_W'(1);
    endfunction

    function automatic logic [EC_W-1:0] sat_inc_ec(input logic [EC_W-1:0] v);
        return (&v) ? v : v + EC_W'(1);
    endfunction

    // comparator input: 2-flop synchroniser, history flop, registered rise detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
            sync_p2_q <= 1'b0;
            rise_p3_q <= 1'b0;
        end else begin
            sync_p0_q <= bus.cross_lo;
            sync_p1_q <= sync_p0_q;
            sync_p2_q <= sync_p1_q;
            rise_p3_q <= sync_p1_q & ~sync_p2_q;
        end
    end

    // Next phase is the first remaining phase with a nonzero length; the
    // candidate lengths depend on which phases are still ahead of us.
    always_comb begin
        c_sel_d   = '0;
        g_sel_d   = '0;
        l_sel_d   = '0;
        nxt_st_d  = DONE;
        nxt_cnt_d = '0;
        case (state_q)
            IDLE: begin
                c_sel_d = bus.charge_len;
                g_sel_d = bus.guard_len;
                l_sel_d = bus.listen_len;
            end
            CHARGE: begin
                g_sel_d = glen_q;
                l_sel_d = llen_q;
            end
            GUARD:   l_sel_d = llen_q;
            default: ;
        endcase
        if (c_sel_d != '0) begin
            nxt_st_d  = CHARGE;
            nxt_cnt_d = c_sel_d - CNT_W'(1);
        end else if (g_sel_d != '0) begin
            nxt_st_d  = GUARD;
            nxt_cnt_d = CNT_W'(g_sel_d) - CNT_W'(1);
        end else if (l_sel_d != '0) begin
            nxt_st_d  = LISTEN;
            nxt_cnt_d = l_sel_d - CNT_W'(1);
        end
    end

    assign advance_d  = (state_q == IDLE) ? (bus.start && !bus.abort)
                      : ((state_q == CHARGE || state_q == GUARD || state_q == LISTEN) && cnt_q == '0);
    assign edge_hit_d = (state_q == LISTEN) && rise_p3_q && !bus.abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            glen_q     <= '0;
            llen_q     <= '0;
            mod_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pv_q       <= 1'b0;
            period_q   <= '0;
            edge_cnt_q <= '0;
            armed_q    <= 1'b0;
            per_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            pv_q   <= 1'b0;
            if (state_q != IDLE && bus.abort) begin
                state_q  <= IDLE;
                mod_en_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (state_q == DONE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (advance_d) begin
                state_q  <= nxt_st_d;
                cnt_q    <= nxt_cnt_d;
                mod_en_q <= (nxt_st_d == CHARGE);
                busy_q   <= 1'b1;
                done_q   <= (nxt_st_d == DONE);
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (state_q == IDLE && advance_d) begin
                glen_q     <= bus.guard_len;
                llen_q     <= bus.listen_len;
                edge_cnt_q <= '0;
                armed_q    <= 1'b0;
            end

            // first edge only arms; later edges report the elapsed count + 1
            if (edge_hit_d) begin
                edge_cnt_q <= sat_inc_ec(edge_cnt_q);
                if (armed_q) begin
                    period_q <= sat_inc_per(per_cnt_q);
                    pv_q     <= 1'b1;
                end
                armed_q   <= 1'b1;
                per_cnt_q <= '0;
            end else if (armed_q) begin
                per_cnt_q <= sat_inc_per(per_cnt_q);
            end
        end
    end

    assign bus.mod_en       = mod_en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.edge_cnt     = edge_cnt_q;
endmodule

// File: tb/tb_lo_passthru_seq.sv
// Bench for lo_passthru_seq: timeline-based reference model checked every cycle,
// a table of phase-placement scenarios, and hand sequences for edge/reset corners.
module tb_lo_passthru_seq;
    localparam int CW   = 16;
    localparam int PW   = 12;
    localparam int EW   = 4;
    localparam int PMAX = 4095;
    localparam int EMAX = 15;
    localparam int HMAX = 131072;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lo_passthru_seq_if #(.CNT_W(CW), .PER_W(PW), .EC_W(EW)) bus ();
    lo_passthru_seq #(.CNT_W(CW), .PER_W(PW), .EC_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cross_lo generator: 0 = low, 1 = square wave of half-period xl_half, 2 = random levels
    int xl_mode = 0;
    int xl_half = 8;
    initial begin : xl_gen
        int   run;
        int   len;
        logic lvl;
        run = 0;
        len = 1;
        lvl = 1'b0;
        bus.cross_lo = 1'b0;
        forever begin
            tick();
            case (xl_mode)
                1: begin
                    run++;
                    if (run >= xl_half) begin run = 0; lvl = ~lvl; end
                end
                2: begin
                    run++;
                    if (run >= len) begin
                        run = 0;
                        lvl = ~lvl;
                        len = int'($urandom_range(1, 6));
                    end
                end
                default: begin run = 0; lvl = 1'b0; end
            endcase
            bus.cross_lo = lvl;
        end
    end

    // Reference model: the read window is a timeline anchored at the start
    // cycle k; edges are detection-cycle stamps and periods are their differences.
    bit xl_h [HMAX];
    int m_k, m_C, m_G, m_L, m_stop, m_prev;
    bit m_act = 1'b0;
    bit m_hp  = 1'b0;
    bit m_pv  = 1'b0;
    int m_ec  = 0;
    int m_per = 0;

    function automatic int phase_at(input int n);
        int r;
        if (!m_act || n > m_stop) return 0;
        r = n - m_k;
        if (r < 1) return 0;
        if (r <= m_C) return 1;
        if (r <= m_C + m_G) return 2;
        if (r <= m_C + m_G + m_L) return 3;
        if (r == m_C + m_G + m_L + 1) return 4;
        return 0;
    endfunction

    // a level first driven high in cycle n is detected in cycle n+3
    function automatic bit det(input int n);
        if (n < 4) return 1'b0;
        return xl_h[n-3] && !xl_h[n-4];
    endfunction

    always @(negedge clk) begin : model
        int n;
        int ph;
        n = cyc;
        if (chk_en) begin
            ph = phase_at(n);
            check("mod_en", longint'(bus.mod_en), longint'(ph == 1));
            check("busy", longint'(bus.busy), longint'(ph != 0));
            check("done", longint'(bus.done), longint'(ph == 4));
            check("period", longint'(bus.period), longint'(m_per));
            check("period_valid", longint'(bus.period_valid), longint'(m_pv));
            check("edge_cnt", longint'(bus.edge_cnt), longint'(m_ec));
        end
        xl_h[n] = bus.cross_lo;
        m_pv = 1'b0;
        if (!rst_n) begin
            xl_h[n] = 1'b0;
            if (n >= 1) xl_h[n-1] = 1'b0;
            if (n >= 2) xl_h[n-2] = 1'b0;
            m_act = 1'b0;
            m_hp  = 1'b0;
            m_ec  = 0;
            m_per = 0;
        end else begin
            ph = phase_at(n);
            if (ph == 3 && !bus.abort && det(n)) begin
                if (m_ec < EMAX) m_ec++;
                if (m_hp) begin
                    m_per = (n - m_prev > PMAX) ? PMAX : n - m_prev;
                    m_pv  = 1'b1;
                end
                m_prev = n;
                m_hp   = 1'b1;
            end
            if (ph != 0 && bus.abort) m_stop = n;
            if (ph == 0 && bus.start && !bus.abort) begin
                m_act  = 1'b1;
                m_k    = n;
                m_C    = int'(bus.charge_len);
                m_G    = int'(bus.guard_len);
                m_L    = int'(bus.listen_len);
                m_stop = 1 << 30;
                m_ec   = 0;
                m_hp   = 1'b0;
            end
        end
    end

    typedef struct {
        int c, g, l;
        int abort_rel;
        int restart_rel;
        int e_busy, e_mod, e_done, e_done_rel;
    } seq_t;
    seq_t tbl [9];

    task automatic set_len(input int c, input int g, input int l);
        bus.charge_len = CW'(c);
        bus.guard_len  = 8'(g);
        bus.listen_len = CW'(l);
    endtask

    task automatic run_seq(input int idx, input seq_t s);
        int nb, nm, nd, drel;
        bit fin;
        nb = 0; nm = 0; nd = 0; drel = -1; fin = 1'b0;
        tick();
        bus.start = 1'b1;
        set_len(s.c, s.g, s.l);
        for (int rel = 1; rel <= 1000 && !fin; rel++) begin
            tick();
            bus.start = (rel == s.restart_rel);
            if (rel == s.restart_rel) set_len(3, 0, 1);
            bus.abort = (rel == s.abort_rel);
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.mod_en) nm++;
            if (bus.done) begin nd++; drel = rel; end
            if (!bus.busy) fin = 1'b1;
        end
        bus.abort = 1'b0;
        check($sformatf("seq%0d_finished", idx), longint'(fin), 1);
        check($sformatf("seq%0d_busy_cycles", idx), nb, s.e_busy);
        check($sformatf("seq%0d_mod_cycles", idx), nm, s.e_mod);
        check($sformatf("seq%0d_done_pulses", idx), nd, s.e_done);
        check($sformatf("seq%0d_done_rel", idx), drel, s.e_done_rel);
    endtask

    // run one window and collect the period_valid stream
    task automatic run_watch(input int c, input int g, input int l, input int exp_per,
                             output int npv, output int first_per, output int bad_per,
                             output int ec_done);
        bit fin;
        npv = 0; first_per = -1; bad_per = 0; ec_done = -1; fin = 1'b0;
        tick();
        bus.start = 1'b1;
        set_len(c, g, l);
        for (int rel = 1; rel <= 25000 && !fin; rel++) begin
            tick();
            bus.start = 1'b0;
            @(negedge clk);
            if (bus.period_valid) begin
                if (npv == 0) first_per = int'(bus.period);
                if (int'(bus.period) != exp_per) bad_per++;
                npv++;
            end
            if (bus.done) ec_done = int'(bus.edge_cnt);
            if (!bus.busy) fin = 1'b1;
        end
        check("watch_finished", longint'(fin), 1);
    endtask

    initial begin : main
        int npv, fp, bad, ecd;
        bit got3;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_len(0, 0, 0);

        tbl[0] = '{10, 2, 20,  -1, -1,  33, 10, 1,  33};
        tbl[1] = '{ 0, 0,  0,  -1, -1,   1,  0, 1,   1};
        tbl[2] = '{ 0, 3,  5,  -1, -1,   9,  0, 1,   9};
        tbl[3] = '{10, 2, 20,   5, -1,   5,  5, 0,  -1};
        tbl[4] = '{10, 2, 20,  -1,  3,  33, 10, 1,  33};
        tbl[5] = '{ 7, 0,  0,  -1, -1,   8,  7, 1,   8};
        tbl[6] = '{ 0, 0,  6,  -1, -1,   7,  0, 1,   7};
        tbl[7] = '{ 3, 4,  5,   9, -1,   9,  3, 0,  -1};
        tbl[8] = '{ 4, 4, 200, -1, -1, 209,  4, 1, 209};

        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_mod_en", longint'(bus.mod_en), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_period", longint'(bus.period), 0);
        check("rst_period_valid", longint'(bus.period_valid), 0);
        check("rst_edge_cnt", longint'(bus.edge_cnt), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 9; i++) run_seq(i, tbl[i]);

        // simultaneous start and abort in IDLE
        tick();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        set_len(5, 1, 5);
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("idle_start_abort_busy", longint'(bus.busy), 0);
        check("idle_start_abort_mod_en", longint'(bus.mod_en), 0);

        // 16-cycle square wave already running before start
        xl_mode = 1;
        xl_half = 8;
        repeat (40) tick();
        run_watch(4, 4, 200, 16, npv, fp, bad, ecd);
        check("per16_first_period", fp, 16);
        check("per16_bad_periods", bad, 0);
        check("per16_enough_pulses", longint'(npv >= 10), 1);
        check("per16_edge_cnt", ecd, npv + 1);

        // period saturation with edges 5000 cycles apart
        xl_half = 2500;
        repeat (10) tick();
        run_watch(0, 0, 20000, PMAX, npv, fp, bad, ecd);
        check("persat_first_period", fp, PMAX);
        check("persat_bad_periods", bad, 0);
        check("persat_enough_pulses", longint'(npv >= 2), 1);

        // edge counter saturation: ~31 edges in the window
        xl_half = 4;
        repeat (10) tick();
        run_watch(0, 0, 250, 8, npv, fp, bad, ecd);
        check("ecsat_edge_cnt", ecd, EMAX);
        check("ecsat_bad_periods", bad, 0);

        // reset in LISTEN after three valid periods
        xl_half = 8;
        tick();
        bus.start = 1'b1;
        set_len(2, 0, 500);
        got3 = 1'b0;
        npv = 0;
        for (int i = 0; i < 400 && !got3; i++) begin
            tick();
            bus.start = 1'b0;
            @(negedge clk);
            if (bus.period_valid) npv++;
            if (npv == 3) got3 = 1'b1;
        end
        check("rstlisten_three_periods", longint'(got3), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstlisten_mod_en", longint'(bus.mod_en), 0);
        check("rstlisten_busy", longint'(bus.busy), 0);
        check("rstlisten_done", longint'(bus.done), 0);
        check("rstlisten_period", longint'(bus.period), 0);
        check("rstlisten_period_valid", longint'(bus.period_valid), 0);
        check("rstlisten_edge_cnt", longint'(bus.edge_cnt), 0);

        // random traffic against the model
        xl_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.start = ($urandom_range(0, 19) == 0);
            bus.abort = ($urandom_range(0, 149) == 0);
            set_len(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 100)));
        end
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (150) tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lo_passthru_seq.md
# lo_passthru_seq

Sequences an LF charge-then-listen read cycle, as used for TI tags, directly in the FPGA. The ARM no longer toggles the modulation line with software timing. On a start request the block drives `mod_en` for a programmed charge time, waits a guard interval, and then opens a listen window. During the window it measures the period between rising edges of the `cross_lo` comparator output and reports each period, plus an edge count, to the ARM-facing logic. `mod_en` feeds the LF passthrough output stage in place of `ssp_dout`.

## Interface
Parameters:
- `CNT_W`, default 24: width of the charge and listen length counters, in clk cycles.
- `PER_W`, default 12: width of the period measurement; the value saturates at 2^PER_W-1.
- `EC_W`, default 16: width of the edge counter; the value saturates.

Ports:
- `clk`  in  1  system clock; the single clock of the block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a read cycle; sampled only in IDLE.
- `abort`  in  1  terminate any cycle; sampled every cycle.
- `charge_len`  in  CNT_W  charge duration in cycles; sampled on start acceptance.
- `guard_len`  in  8  guard duration in cycles; sampled on start acceptance.
- `listen_len`  in  CNT_W  listen duration in cycles; sampled on start acceptance.
- `cross_lo`  in  1  asynchronous comparator output.
- `mod_en`  out  1  antenna drive enable (charge phase).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a listen window completes normally.
- `period`  out  PER_W  last measured edge-to-edge period; held between updates.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `edge_cnt`  out  EC_W  rising edges seen in the current or last listen window.

## Operation
- **Input synchronisation:** `cross_lo` passes through a 2-flop synchroniser, then a rising-edge detector. This path runs in every state; it is reset to 0.
- **States:** IDLE, CHARGE, GUARD, LISTEN, DONE.
- **IDLE:**
  - If `start`=1 and `abort`=0, latch the three lengths, clear `edge_cnt`, and disarm the period measurement.
  - Next state is the first of CHARGE, GUARD, LISTEN whose latched length is nonzero; if all are zero, go to DONE.
- **CHARGE:** `mod_en`=1. Stay for exactly `charge_len` cycles, then go to the next nonzero phase.
- **GUARD:** `mod_en`=0 and edges are ignored. Stay for `guard_len` cycles.
- **LISTEN:** `mod_en`=0. Stay for `listen_len` cycles, then go to DONE. On each detected edge:
  - `edge_cnt` increments, saturating at 2^EC_W-1.
  - The first edge only arms the period counter and clears it to 0.
  - Each later edge loads `period` with min(cycles since the previous edge, 2^PER_W-1), pulses `period_valid`, and restarts the count.
  - The period counter saturates and does not wrap.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Abort:** in any non-IDLE state, `abort`=1 forces IDLE on the next edge. `mod_en` drops the same edge and `done` does not pulse. `period` and `edge_cnt` keep their values.
- **Start/abort priority:** in IDLE, `abort` has priority over `start`. `start` in any non-IDLE state is ignored and is not queued.
- **Length inputs:** changes to the length inputs while `busy`=1 have no effect on the running cycle.
- **Reset:** `rst_n`=0 at any clock edge, including mid-CHARGE, forces IDLE.
  - All outputs reset to 0: `mod_en`, `busy`, `done`, `period_valid`, `period`, `edge_cnt`.
  - The synchroniser flops and all counters reset to 0.

## Timing
- All outputs are registered.
- With `start` high in cycle k, `busy` rises in k+1.
- Phase placement for lengths C, G, L:
  - `mod_en` is high in cycles k+1 .. k+C.
  - GUARD occupies k+C+1 .. k+C+G.
  - LISTEN occupies k+C+G+1 .. k+C+G+L.
  - `done` is high in k+C+G+L+1.
  - `busy` falls in k+C+G+L+2.
- Edge latency: a `cross_lo` rise that is stable before edge t is detected in cycle t+2. `period_valid` and the `edge_cnt` update appear in cycle t+3.
- An edge counts only if its detection cycle lies in LISTEN.
- Minimum measurable period is 2 cycles; edges closer together are undefined.
- Back-to-back: the earliest next `start` is accepted in the cycle after `done`.

## Test plan
- **Basic sequence:** C=10, G=2, L=20, `start` at cycle 0, `cross_lo`=0 → `mod_en` high in cycles 1–10, `done` at cycle 33, `busy` low at 34, `edge_cnt`=0.
- **Period measurement:** C=4, G=4, L=200; a `cross_lo` square wave with a 16-cycle period starts before `start` → the first `period_valid` carries 16, then 16 every 16 cycles; `edge_cnt` = number of edges detected in LISTEN (±1 at the window boundaries, checked against the model).
- **Saturation:** PER_W=12, edges 5000 cycles apart within L=20000 → `period`=4095. With EC_W=4 and 20 edges → `edge_cnt`=15.
- **Abort:** `abort` at cycle 5 of CHARGE → `mod_en` low next cycle, `busy` low, no `done`. A simultaneous `start`+`abort` in IDLE → stays IDLE.
- **Zero lengths:** C=0, G=0, L=0 → `done` pulses 1 cycle after `start`, `mod_en` never high. C=0, G=3, L=5 → `mod_en` never high, `done` at k+9.
- **Reset and ignored start:** `rst_n` low mid-LISTEN after 3 valid periods → all outputs 0 the next cycle. Separately, `start` during CHARGE with new lengths has no effect on the current phase lengths.
